// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target bridging bus write/read transfers onto an 8-bit register interface.
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int NUM_REGS = 16,
    parameter int AW = $clog2(NUM_REGS),
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_we,
    output logic          reg_re,
    input  logic [7:0]    reg_rdata,
    output logic          busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
    } state_t;

    state_t state, state_n;
    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic scl_s, sda_s, scl_d, sda_d, scl_rise, scl_fall, start, stop, ptr_ok;
    logic [2:0] bit_cnt, cnt_n;
    logic [7:0] shreg, sh_n, wd_n, byte_in;
    logic ack_ph, ph_n, rw, rw_n, re_d, oe_n, busy_n, we_n, re_n;
    logic [AW-1:0] ptr_n, ptr_inc;

    assign scl_s = scl_q[SYNC_STAGES-1];
    assign sda_s = sda_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start = scl_s & scl_d & sda_d & ~sda_s;
    assign stop = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_in = {shreg[6:0], sda_s};
    assign ptr_ok = {1'b0, byte_in} < 9'(NUM_REGS);
    assign ptr_inc = (reg_addr == AW'(NUM_REGS - 1)) ? '0 : reg_addr + 1'b1;

    always_comb begin
        state_n = state;
        oe_n = sda_oe;
        busy_n = busy;
        we_n = 1'b0;
        re_n = 1'b0;
        ptr_n = reg_addr;
        cnt_n = bit_cnt;
        sh_n = shreg;
        ph_n = ack_ph;
        rw_n = rw;
        wd_n = reg_wdata;
        // read data arrives one clk after the strobe; first bit goes out immediately
        if (re_d && state == RDATA) begin
            sh_n = reg_rdata;
            oe_n = ~reg_rdata[7];
        end
        if (stop) begin
            state_n = IDLE;
            oe_n = 1'b0;
            busy_n = 1'b0;
        end else if (start) begin
            state_n = ADDR;
            oe_n = 1'b0;
            busy_n = 1'b0;
            cnt_n = '0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: if (scl_rise) begin
                    sh_n = byte_in;
                    cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        ph_n = 1'b0;
                        if (state == ADDR) begin
                            state_n = (byte_in[7:1] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
                            busy_n = byte_in[7:1] == TARGET_ADDR;
                            rw_n = byte_in[0];
                        end else if (state == PTR) begin
                            state_n = ptr_ok ? PTR_ACK : WAIT_STOP;
                            ptr_n = ptr_ok ? byte_in[AW-1:0] : reg_addr;
                        end else begin
                            we_n = 1'b1;
                            wd_n = byte_in;
                            state_n = WDATA_ACK;
                        end
                    end
                end
                // first falling edge starts the ACK drive, second one ends the slot
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_rise) begin
                    ph_n = 1'b1;
                end else if (scl_fall) begin
                    oe_n = ~ack_ph;
                    if (ack_ph) begin
                        state_n = (state == ADDR_ACK) ? (rw ? RDATA : PTR) : WDATA;
                        re_n = state == ADDR_ACK && rw;
                        ptr_n = (state == WDATA_ACK) ? ptr_inc : reg_addr;
                    end
                end
                RDATA: if (scl_fall) begin
                    cnt_n = bit_cnt + 3'd1;
                    sh_n = {shreg[6:0], 1'b0};
                    oe_n = ~shreg[6];
                    if (bit_cnt == 3'd7) begin
                        oe_n = 1'b0;
                        ph_n = 1'b0;
                        state_n = RACK;
                    end
                end
                RACK: if (scl_rise) begin
                    ph_n = ~sda_s;
                    ptr_n = sda_s ? reg_addr : ptr_inc;
                end else if (scl_fall) begin
                    state_n = ack_ph ? RDATA : WAIT_STOP;
                    re_n = ack_ph;
                end
                WAIT_STOP: busy_n = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
            state <= IDLE;
            sda_oe <= 1'b0;
            busy <= 1'b0;
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            re_d <= 1'b0;
            reg_addr <= '0;
            reg_wdata <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            ack_ph <= 1'b0;
            rw <= 1'b0;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl_i};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda_i};
            scl_d <= scl_s;
            sda_d <= sda_s;
            state <= state_n;
            sda_oe <= oe_n;
            busy <= busy_n;
            reg_we <= we_n;
            reg_re <= re_n;
            re_d <= reg_re;
            reg_addr <= ptr_n;
            reg_wdata <= wd_n;
            bit_cnt <= cnt_n;
            shreg <= sh_n;
            ack_ph <= ph_n;
            rw <= rw_n;
        end
    end
endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
Parametrised I2C target that bridges an I2C bus to an on-chip 8-bit register interface. It supports both write and read transfers, a register pointer with auto-increment and wrap, repeated START, and NACK on address or pointer mismatch. SCL and SDA are oversampled on the system clock, so the block is fully synchronous. It sits between the pad open-drain cells and a register bank or other control logic.

Parameters:
TARGET_ADDR, 7'h42, 7-bit bus address the block responds to.
NUM_REGS, 16, number of addressable registers (2..256).
AW, $clog2(NUM_REGS), register address width (derived).
SYNC_STAGES, 2, synchroniser depth on scl_i and sda_i (>=2).

Ports:
clk  input  1  system clock; must run at >=20x the SCL rate.
rst_n  input  1  asynchronous active-low reset.
scl_i  input  1  SCL from pad.
sda_i  input  1  SDA from pad.
sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
reg_addr  output  AW  register pointer for the current access.
reg_wdata  output  8  write data; valid while reg_we=1.
reg_we  output  1  one-clk write strobe.
reg_re  output  1  one-clk read strobe.
reg_rdata  input  8  read data; must be valid one clk after reg_re.
busy  output  1  high while the block is addressed.

Behaviour:
- Reset: sda_oe=0, reg_we=0, reg_re=0, reg_wdata=0, busy=0, pointer (reg_addr)=0, state=IDLE. An asserted rst_n releases SDA immediately, including mid-transfer.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- SDA is sampled on synchronised SCL rising edges. sda_oe changes only one clk after synchronised SCL falling edges, except at STOP, reset and mismatch release.
- Bytes are MSB first. The 9th clock of each byte is the ACK slot. ACK means sda_oe=1 for that whole SCL low+high period. NACK means sda_oe=0.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
- IDLE→ADDR on START.
- ADDR: after 8 bits, compare the top 7 bits with TARGET_ADDR.
  - Match → ADDR_ACK with ACK, and busy=1.
  - Mismatch, including general call 0x00 → WAIT_STOP, SDA never driven.
- ADDR_ACK:
  - R/W=0 → PTR.
  - R/W=1 → reg_re pulses in the clk after the SCL falling edge that ends the ACK slot, then RDATA.
- PTR: the received byte is the pointer.
  - Byte < NUM_REGS → load pointer and ACK.
  - Otherwise → NACK, pointer unchanged, then WAIT_STOP.
- PTR_ACK→WDATA.
- WDATA: after the 8th bit is sampled, reg_we pulses for one clk with reg_addr=pointer and reg_wdata=byte. Then WDATA_ACK (always ACK), then pointer = (pointer+1) wrapping NUM_REGS-1→0, then WDATA.
- RDATA: reg_rdata is captured into the shift register one clk after reg_re. sda_oe=~bit for each bit, set after each SCL falling edge. After 8 bits → RACK (SDA released).
- RACK: sample the master's bit.
  - ACK(0) → pointer increments with wrap, reg_re pulses at the next SCL falling edge, RDATA.
  - NACK(1) → WAIT_STOP.
- Repeated START in any non-IDLE state → ADDR. SDA is released, the pointer is retained, and busy clears until the next address match.
- STOP in any state → IDLE: sda_oe=0 and busy=0 the clk after detection. A partial byte is discarded with no strobe.
- reg_we and reg_re are never asserted in the same clk. At most one strobe occurs per byte.
- busy falls in WAIT_STOP after a NACK and after a mismatch.

Test Plan:
1. Multi-byte write: START, 0x84, 0x03, 0xA5, 0x5A, STOP -> all four bytes ACKed; reg_we pulses with (addr 3, 0xA5) then (addr 4, 0x5A); busy falls after STOP.
2. Read with wrap: write pointer 0x0E, Sr, 0x85, master reads three bytes ACK/ACK/NACK, reg_rdata = 0x10+addr -> reg_re at addresses 0x0E, 0x0F, 0x00; SDA carries 0x1E, 0x1F, 0x10.
3. Address mismatch: START, 0x86, two more bytes, STOP -> sda_oe stays 0 throughout; no strobes; busy stays 0.
4. Bad pointer: START, 0x84, 0x10, 0x77, STOP -> address ACKed, 0x10 NACKed, 0x77 not ACKed; no reg_we; pointer keeps its previous value.
5. Abort: STOP after 4 bits of a data byte -> no reg_we; sda_oe=0; a following write of 0x01, 0xC3 succeeds (reg_we at addr 1, 0xC3).
6. rst_n low mid-read while sda_oe=1 -> sda_oe=0 asynchronously; pointer=0; busy=0; the next 0x85 read returns reg_rdata for address 0.
